fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Sits directly downstream of the fetch unit's program counter and instruction-memory read address.
- Accepts the current PC, issues an instruction-memory read, and tracks outstanding reads in order.
- Buffers each returned instruction together with its PC.
- Presents instruction/PC pairs to the decode stage over a valid/ready handshake.
- Supports a single-cycle flush on control-flow redirect; all in-flight memory responses issued before the flush are discarded.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries and maximum outstanding reads; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- i_pc_valid  in  1  PC stage presents a fetch address
- i_pc_data  in  XLEN  fetch address
- o_pc_ready  out  1  fetch accepted this cycle; PC may advance
- i_flush  in  1  redirect: discard queue contents and in-flight reads
- o_im_req_valid  out  1  instruction-memory read request
- o_im_req_addr  out  XLEN  read address
- i_im_req_ready  in  1  memory accepts request
- i_im_rsp_valid  in  1  read data returned, strictly in request order
- i_im_rsp_data  in  XLEN  instruction word
- o_id_valid  out  1  head entry valid for decode
- o_id_instr  out  XLEN  head instruction
- o_id_pc  out  XLEN  head PC
- i_id_ready  in  1  decode consumes head

Behaviour:
- Storage is a circular buffer of DEPTH entries {pc, instr, filled}.
- Three pointers, each clog2(DEPTH)+1 bits wide with wrap bit:
  - alloc_ptr: next entry to allocate.
  - fill_ptr: next entry awaiting a response.
  - rd_ptr: head entry.
- Derived quantities:
  - occupancy = alloc_ptr - rd_ptr (modular).
  - outstanding = alloc_ptr - fill_ptr.
- drop_cnt: 0..DEPTH, counts stale responses still to be discarded.
- Space condition: space = (occupancy + drop_cnt) < DEPTH, computed from registered state only. A pop in the same cycle does not free a slot until the next cycle (no bypass).
- Request path (combinational):
  - o_im_req_valid = i_pc_valid & space & !i_flush.
  - o_im_req_addr = i_pc_data.
  - o_pc_ready = o_im_req_valid & i_im_req_ready.
- On o_pc_ready: write pc into entry[alloc_ptr], clear its filled bit, increment alloc_ptr.
- Response path on i_im_rsp_valid:
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: write instr into entry[fill_ptr], set filled, increment fill_ptr.
  - A response while drop_cnt = 0 and outstanding = 0 is a protocol error; ignore it (assertion in the bench).
- Decode path:
  - o_id_valid = (occupancy != 0) & entry[rd_ptr].filled & !i_flush.
  - o_id_instr and o_id_pc come from entry[rd_ptr].
  - When o_id_valid & i_id_ready: increment rd_ptr.
- Latency: request accepted in cycle N, response in cycle M > N, o_id_valid at M+1 if the entry is at the head. No combinational path from i_im_rsp_* to o_id_*.
- Flush (registered effect):
  - alloc_ptr, fill_ptr, rd_ptr all set to 0.
  - drop_cnt <= drop_cnt + outstanding - (i_im_rsp_valid ? 1 : 0). A response arriving in the flush cycle is itself discarded.
  - No request and no pop occur in the flush cycle.
  - A request in the cycle after the flush is allowed if space permits (drop_cnt counts against space).
- Simultaneous events:
  - Allocate, fill and pop in one cycle are all legal and independent.
  - Fill and pop of the same entry in one cycle cannot occur, because filled is registered.
- Full queue: o_im_req_valid = 0 while i_pc_valid is held. The PC stage must hold i_pc_data stable until o_pc_ready.
- Reset (rstn = 0 at clk edge):
  - Pointers = 0, drop_cnt = 0, all filled bits = 0.
  - o_id_valid = 0, o_im_req_valid = 0, o_pc_ready = 0.
  - o_id_instr and o_id_pc = 0 (storage reset).
  - A reset mid-operation discards everything, including outstanding reads. The memory side must also be reset in the same cycle.

Decomposition:
- Shared package fetch_pkg: entry struct typedef {pc, instr, filled}; constant NOP_INSTR = 32'h0000_0013 for bench idle checks.
- One sub-module, fetch_queue_mem: DEPTH x entry storage with write-alloc, write-fill and read ports.
- Pointer, credit and drop logic stay in the top.

Test Plan:
- Reset then idle: rstn low 2 cycles, i_pc_valid=0 -> all outputs 0; o_pc_ready=0 for 4 cycles.
- Sequential fetch, 1-cycle memory: PCs 0x0,0x4,0x8,0xC, responses 0x13,0x00500093,0x00A00113,0x002081B3; i_id_ready=1 -> decode sees those four (pc, instr) pairs in order, one per cycle, first o_id_valid 2 cycles after first accept.
- Backpressure/full: i_id_ready=0, DEPTH=4, PC 0x100 held valid -> exactly 4 accepts (0x100..0x10C), then o_im_req_valid=0. Raise i_id_ready -> one new accept the cycle after the first pop.
- Flush with 3 outstanding: accept 0x20,0x24,0x28, no responses, i_flush=1 -> next 3 responses discarded. New fetch 0x400 with response 0xDEADBEEF -> o_id_pc=0x400, o_id_instr=0xDEADBEEF.
- Flush coincident with response: 2 outstanding, i_flush and i_im_rsp_valid same cycle -> drop_cnt=1; only the following single response is dropped.
- Variable latency, in order: responses return 0,3,1 cycles apart with random i_id_ready -> ordering preserved, no loss or duplication (scoreboard), space never exceeded.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch queue
package fetch_pkg;

    // Width of one stored PC / instruction word; entry_t is sized from it.
    localparam int FETCH_XLEN = 32;

    // Canonical RISC-V nop (addi x0, x0, 0).
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One queue slot: fetch address, returned word and a "word has arrived" flag.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  filled;
    } entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - PC, instruction-memory and decode handshakes of the fetch queue
interface fetch_queue_if #(
    parameter int XLEN = fetch_pkg::FETCH_XLEN
);

    logic            i_pc_valid;
    logic [XLEN-1:0] i_pc_data;
    logic            o_pc_ready;
    logic            i_flush;

    logic            o_im_req_valid;
    logic [XLEN-1:0] o_im_req_addr;
    logic            i_im_req_ready;
    logic            i_im_rsp_valid;
    logic [XLEN-1:0] i_im_rsp_data;

    logic            o_id_valid;
    logic [XLEN-1:0] o_id_instr;
    logic [XLEN-1:0] o_id_pc;
    logic            i_id_ready;

    // Queue side.
    modport slave (
        input  i_pc_valid, i_pc_data, i_flush,
        input  i_im_req_ready, i_im_rsp_valid, i_im_rsp_data,
        input  i_id_ready,
        output o_pc_ready, o_im_req_valid, o_im_req_addr,
        output o_id_valid, o_id_instr, o_id_pc
    );

    // Surrounding pipeline / memory side.
    modport master (
        output i_pc_valid, i_pc_data, i_flush,
        output i_im_req_ready, i_im_rsp_valid, i_im_rsp_data,
        output i_id_ready,
        input  o_pc_ready, o_im_req_valid, o_im_req_addr,
        input  o_id_valid, o_id_instr, o_id_pc
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH-entry slot storage with allocate, fill and read ports
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  alloc_en_i,
    input  logic [AW-1:0]         alloc_idx_i,
    input  logic [FETCH_XLEN-1:0] alloc_pc_i,
    input  logic                  fill_en_i,
    input  logic [AW-1:0]         fill_idx_i,
    input  logic [FETCH_XLEN-1:0] fill_instr_i,
    input  logic [AW-1:0]         rd_idx_i,
    output entry_t                rd_entry_o
);

    entry_t mem_q [DEPTH];

    // Allocate and fill always target different slots: fill hits an occupied
    // slot, allocate only ever writes a free one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (alloc_en_i) begin
                mem_q[alloc_idx_i].pc     <= alloc_pc_i;
                mem_q[alloc_idx_i].filled <= 1'b0;
            end
            if (fill_en_i) begin
                mem_q[fill_idx_i].instr  <= fill_instr_i;
                mem_q[fill_idx_i].filled <= 1'b1;
            end
        end
    end

    assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with flush and stale-response dropping
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = FETCH_XLEN,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    fetch_queue_if.slave  bus
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             PW      = AW + 1;
    localparam logic [PW:0]    DEPTH_W = (PW+1)'(DEPTH);

    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0] drop_cnt_q,  drop_cnt_d;

    logic [PW-1:0] occupancy;
    logic [PW-1:0] outstanding;
    logic [PW:0]   committed;
    logic          space;
    logic          alloc_en;
    logic          fill_en;
    logic          rsp_drop;
    logic          pop_en;
    entry_t        head;

    // Slots are owed both to live entries and to stale reads still in flight,
    // so both count against space; only registered state is used.
    assign occupancy   = alloc_ptr_q - rd_ptr_q;
    assign outstanding = alloc_ptr_q - fill_ptr_q;
    assign committed   = {1'b0, occupancy} + {1'b0, drop_cnt_q};
    assign space       = committed < DEPTH_W;

    assign bus.o_im_req_valid = bus.i_pc_valid & space & ~bus.i_flush;
    assign bus.o_im_req_addr  = bus.i_pc_data;
    assign bus.o_pc_ready     = bus.o_im_req_valid & bus.i_im_req_ready;
    assign alloc_en           = bus.o_pc_ready;

    // Stale responses are consumed first; a response with nothing owed is ignored.
    assign rsp_drop = bus.i_im_rsp_valid & (drop_cnt_q != '0);
    assign fill_en  = bus.i_im_rsp_valid & (drop_cnt_q == '0) & (outstanding != '0) & ~bus.i_flush;

    assign bus.o_id_valid = (occupancy != '0) & head.filled & ~bus.i_flush;
    assign bus.o_id_instr = head.instr;
    assign bus.o_id_pc    = head.pc;
    assign pop_en         = bus.o_id_valid & bus.i_id_ready;

    // Next-state for pointers and the stale-response counter.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        if (bus.i_flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            drop_cnt_d  = drop_cnt_q + outstanding;
            if (bus.i_im_rsp_valid && (drop_cnt_d != '0)) begin
                drop_cnt_d = drop_cnt_d - PW'(1);
            end
        end else begin
            if (alloc_en) alloc_ptr_d = alloc_ptr_q + PW'(1);
            if (fill_en)  fill_ptr_d  = fill_ptr_q  + PW'(1);
            if (pop_en)   rd_ptr_d    = rd_ptr_q    + PW'(1);
            if (rsp_drop) drop_cnt_d  = drop_cnt_q  - PW'(1);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk          (clk),
        .rstn         (rstn),
        .alloc_en_i   (alloc_en),
        .alloc_idx_i  (alloc_ptr_q[AW-1:0]),
        .alloc_pc_i   (bus.i_pc_data),
        .fill_en_i    (fill_en),
        .fill_idx_i   (fill_ptr_q[AW-1:0]),
        .fill_instr_i (bus.i_im_rsp_data),
        .rd_idx_i     (rd_ptr_q[AW-1:0]),
        .rd_entry_o   (head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ment_t;

    int          checks = 0;
    int          errors = 0;
    ment_t       m_q[$];
    int          m_drop;
    int          mem_pend;
    int          cyc;
    int          first_acc;
    int          first_idv;
    bit          last_acc;
    bit          last_pop;
    bit          last_req;
    logic [63:0] popped[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_unfilled();
        int n = 0;
        foreach (m_q[i]) if (!m_q[i].filled) n++;
        return n;
    endfunction

    task automatic step(input logic pv, input logic [31:0] pc, input logic fl,
                        input logic rq_rdy, input logic rv, input logic [31:0] rd,
                        input logic idr);
        bit rv_eff, sp, exp_req, exp_acc, exp_idv;
        int outs;
        rv_eff = rv && (mem_pend > 0);
        bus.i_pc_valid     = pv;
        bus.i_pc_data      = pc;
        bus.i_flush        = fl;
        bus.i_im_req_ready = rq_rdy;
        bus.i_im_rsp_valid = rv_eff;
        bus.i_im_rsp_data  = rd;
        bus.i_id_ready     = idr;
        #1;
        sp      = (m_q.size() + m_drop) < DEPTH;
        exp_req = pv && sp && !fl;
        exp_acc = exp_req && rq_rdy;
        exp_idv = (m_q.size() != 0) && m_q[0].filled && !fl;
        outs    = m_unfilled();
        check("im_req_valid", 32'(bus.o_im_req_valid), 32'(exp_req));
        check("pc_ready", 32'(bus.o_pc_ready), 32'(exp_acc));
        check("id_valid", 32'(bus.o_id_valid), 32'(exp_idv));
        if (exp_req) check("im_req_addr", bus.o_im_req_addr, pc);
        if (exp_idv) begin
            check("id_pc", bus.o_id_pc, m_q[0].pc);
            check("id_instr", bus.o_id_instr, m_q[0].instr);
        end
        check("rsp_protocol", 32'(rv_eff && m_drop == 0 && outs == 0), 32'd0);
        last_req = bus.o_im_req_valid;
        last_acc = bus.o_pc_ready;
        last_pop = bus.o_id_valid && idr;
        if (last_acc && first_acc < 0) first_acc = cyc;
        if (bus.o_id_valid && first_idv < 0) first_idv = cyc;
        if (last_pop) popped.push_back({bus.o_id_pc, bus.o_id_instr});
        @(posedge clk);
        if (fl) begin
            m_drop = m_drop + outs;
            if (rv_eff && m_drop > 0) m_drop--;
            m_q.delete();
        end else begin
            if (rv_eff) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < m_q.size(); i++) begin
                        if (!m_q[i].filled) begin
                            m_q[i].instr  = rd;
                            m_q[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (exp_idv && idr) void'(m_q.pop_front());
            if (exp_acc) m_q.push_back('{pc: pc, instr: 32'h0, filled: 1'b0});
        end
        if (last_acc) mem_pend++;
        if (rv_eff) mem_pend--;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b1, mem_pend > 0, $urandom, 1'b1);
    endtask

    logic [31:0] seq_instr [4];
    logic [31:0] pc;
    int          acc_cnt;
    int          gap;
    logic [63:0] pair;

    initial begin
        seq_instr[0] = NOP_INSTR;
        seq_instr[1] = 32'h0050_0093;
        seq_instr[2] = 32'h00A0_0113;
        seq_instr[3] = 32'h0020_81B3;

        // Reset then idle.
        rstn = 1'b0;
        bus.i_pc_valid = 0; bus.i_pc_data = 0; bus.i_flush = 0; bus.i_im_req_ready = 1;
        bus.i_im_rsp_valid = 0; bus.i_im_rsp_data = 0; bus.i_id_ready = 0;
        m_q.delete(); m_drop = 0; mem_pend = 0; cyc = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk); #1;
            check("rst_req_valid", 32'(bus.o_im_req_valid), 32'd0);
            check("rst_pc_ready", 32'(bus.o_pc_ready), 32'd0);
            check("rst_id_valid", 32'(bus.o_id_valid), 32'd0);
            check("rst_id_instr", bus.o_id_instr, 32'd0);
            check("rst_id_pc", bus.o_id_pc, 32'd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check("idle_pc_ready", 32'(last_acc), 32'd0);
        end

        // Sequential fetch with a one-cycle memory.
        first_acc = -1; first_idv = -1; popped.delete();
        for (int i = 0; i < 7; i++) begin
            step(i < 4, 32'(4 * i), 1'b0, 1'b1, (i >= 1 && i <= 4),
                 (i >= 1 && i <= 4) ? seq_instr[(i + 3) % 4] : 32'h0, 1'b1);
        end
        check("seq_first_valid_latency", 32'(first_idv - first_acc), 32'd2);
        check("seq_pop_count", 32'(popped.size()), 32'd4);
        for (int k = 0; k < 4 && k < popped.size(); k++) begin
            pair = popped[k];
            check("seq_pc", pair[63:32], 32'(4 * k));
            check("seq_instr", pair[31:0], seq_instr[k]);
        end

        // Backpressure until full, then release one pop.
        pc = 32'h100; acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pc, 1'b0, 1'b1, mem_pend > 0, $urandom, 1'b0);
            if (last_acc) begin acc_cnt++; pc = pc + 32'd4; end
        end
        check("full_accepts", 32'(acc_cnt), 32'd4);
        check("full_next_pc", pc, 32'h110);
        check("full_req_valid", 32'(last_req), 32'd0);
        step(1'b1, pc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("full_pop_cycle_pop", 32'(last_pop), 32'd1);
        check("full_pop_cycle_acc", 32'(last_acc), 32'd0);
        step(1'b1, pc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full_after_pop_acc", 32'(last_acc), 32'd1);
        drain(16);

        // Flush with three reads outstanding.
        step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h28, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h2C, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        check("flush3_accept_after", 32'(last_acc), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        check("flush3_id_valid", 32'(bus.o_id_valid), 32'd1);
        check("flush3_id_pc", bus.o_id_pc, 32'h400);
        check("flush3_id_instr", bus.o_id_instr, 32'hDEAD_BEEF);
        drain(4);

        // Flush coincident with a response.
        step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4444_4444, 1'b1);
        step(1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
        #1;
        check("flushrsp_id_valid", 32'(bus.o_id_valid), 32'd1);
        check("flushrsp_id_pc", bus.o_id_pc, 32'h500);
        check("flushrsp_id_instr", bus.o_id_instr, 32'hCAFE_0001);
        drain(4);

        // Randomized traffic with 0/3/1-cycle response gaps and occasional flushes.
        pc = 32'h1000; gap = 0;
        for (int i = 0; i < 600; i++) begin
            logic fl, rv;
            fl = ($urandom_range(0, 31) == 0);
            rv = (mem_pend > 0) && (gap == 0);
            if (rv) begin
                case ($urandom_range(0, 2))
                    0: gap = 0;
                    1: gap = 3;
                    default: gap = 1;
                endcase
            end else if (gap > 0) begin
                gap--;
            end
            step($urandom_range(0, 3) != 0, pc, fl, $urandom_range(0, 3) != 0, rv,
                 $urandom, $urandom_range(0, 1) == 1);
            if (fl) pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            else if (last_acc) pc = pc + 32'd4;
        end
        drain(24);
        check("end_mem_pending", 32'(mem_pend), 32'd0);
        check("end_id_valid", 32'(bus.o_id_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
